prio_arbiter_rr: RTL and testbench
==================================

Name: prio_arbiter_rr

Overview:
Parametrised N-way priority arbiter with a registered grant. It generalises the 4:2 priority encoder in two ways: any request width, and a selectable fixed-priority or round-robin mode. A granted requester keeps the grant, held stable, until the consumer acknowledges it. The block sits between N request sources and one shared resource.

Parameters:
- N, 4, number of requesters; legal range N >= 2, power of two not required.
- W, max(1,$clog2(N)), width of grant_idx; derived, not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N  request vector; bit i high means requester i wants the resource.
- mode  input  1  0 = fixed priority, highest index wins; 1 = round-robin.
- ack  input  1  consumer accepts the current grant; only meaningful while grant_valid=1.
- grant_valid  output  1  a grant is held.
- grant_idx  output  W  index of the granted requester.
- grant_onehot  output  N  one-hot form of grant_idx; all zeros when grant_valid=0.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - grant_valid=0, grant_idx=0, grant_onehot=0.
  - state=IDLE; rr pointer ptr=N-1.
  - Reset overrides everything, including a held grant: the grant drops with no ack needed.
- All outputs are registered. Latency from req sampled to grant visible is 1 cycle.
- State IDLE:
  - If |req=1, select a winner, register grant_valid=1, grant_idx and grant_onehot, then go to GRANT.
  - Otherwise stay in IDLE; outputs stay at their reset values.
- State GRANT:
  - While ack=0, grant_idx, grant_onehot and grant_valid are frozen.
  - Changes to req (including the winner dropping its request) and changes to mode are ignored until ack.
- Ack edge (grant_valid=1 and ack=1 sampled):
  - Update the pointer: ptr <= (grant_idx==0) ? N-1 : grant_idx-1. The pointer updates in both modes but is only used in mode 1.
  - Re-arbitrate in the same edge, using req and mode as sampled at that edge and the updated ptr.
  - If any req bit is set, the new winner is registered, state stays GRANT, and grant_valid stays 1. Holding ack=1 therefore gives one grant per cycle.
  - If req=0, go to IDLE with grant_valid=0, grant_idx=0, grant_onehot=0.
- ack while grant_valid=0 is ignored and has no effect on ptr.
- Selection, mode 0: the highest set index of req wins; ptr is not consulted.
  - Lower indices can starve; this is intended.
- Selection, mode 1: search starts at the pointer and descends with wrap-around: ptr, ptr-1, …, 0, N-1, …, ptr+1; the first set bit wins.
  - In the IDLE-to-GRANT case, ptr is the stored pointer.
  - In the ack case, ptr is the post-update value, so the just-served requester has lowest priority.
- Since the pointer resets to N-1, the first round-robin grant after reset matches the fixed-priority winner.
- Mode switch is effective only at an arbitration point (IDLE with requests, or an ack edge). ptr is retained across mode switches.
- Invariant: grant_onehot == (1 << grant_idx) whenever grant_valid=1, and exactly one bit is set.
- Implementation:
  - Rotate-and-priority-encode or double-width masking are both acceptable.
  - The combinational winner logic is a pure function of req, mode and the pointer value in use.
  - There are no latches and no combinational path from req to outputs.

Test Plan:
- Reset: N=4, req=4'b1111, rst_n=0 for 2 edges -> grant_valid=0, grant_idx=0, grant_onehot=0. After rst_n=1, the first edge gives grant_idx=3.
- Fixed hold: mode=0, req=4'b1011, ack=0 -> one edge later grant_valid=1, grant_idx=3, grant_onehot=4'b1000. Then change req to 4'b0010 for 3 cycles -> grant_idx stays 3. Then ack=1 for one edge -> grant_idx=1.
- Fixed starvation: mode=0, req=4'b0101 held, ack=1 held -> grant_idx=2 every cycle and grant_valid never drops.
- Round-robin rotation: mode=1 after reset, req=4'b1111, ack=1 held -> grant_idx sequence 3,2,1,0,3,2 on consecutive cycles. With req=4'b1010 instead -> 3,1,3,1.
- Drain to idle: mode=1, single req=4'b0100 pulsed for 1 cycle, ack=1 on the grant cycle -> grant_idx=2 for one cycle, then grant_valid=0 and grant_onehot=0. A spurious ack=1 while idle leaves the next round-robin order unchanged.
- Reset mid-grant: mode=1, grant held on idx 2 with ack=0, rst_n=0 for 1 edge -> grant_valid=0. After release with req=4'b1111, the first grant is idx 3 (pointer reset to N-1).

Source files
------------

// File: rtl/prio_arbiter_rr.sv
// N-way arbiter with a registered grant that is held until acknowledged.
// mode=0 gives fixed priority (highest index wins).
// mode=1 gives round-robin, searching downward from a pointer with wrap-around.
module prio_arbiter_rr #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] PTR_RESET  = W'(N - 1);
  localparam logic [N-1:0] ONEHOT_ONE = N'(1);

  state_t       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         grant_valid_q, grant_valid_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;

  // An ack only counts while a grant is actually held.
  logic         ack_edge;
  // Pointer after serving the current grant: the served index gets lowest priority.
  logic [W-1:0] ptr_served;
  // Pointer value the winner search starts from at this edge.
  logic [W-1:0] ptr_use;
  logic         arb_point;
  logic [W-1:0] win_idx;

  assign ack_edge   = (state_q == GRANT) && ack;
  assign ptr_served = (grant_idx_q == '0) ? PTR_RESET : (grant_idx_q - W'(1));
  assign ptr_use    = ack_edge ? ptr_served : ptr_q;
  assign arb_point  = (state_q == IDLE) || ack_edge;

  // Winner selection: a pure function of req, mode and ptr_use.
  always_comb begin
    logic         found;
    int           pos_int;
    logic [W-1:0] pos;
    found   = 1'b0;
    pos_int = 0;
    pos     = '0;
    win_idx = '0;
    if (!mode) begin
      // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          win_idx = W'(i);
        end
      end
    end else begin
      // Search ptr, ptr-1, ..., 0, N-1, ..., ptr+1 and take the first set bit.
      for (int k = 0; k < N; k++) begin
        pos_int = int'(ptr_use) - k;
        if (pos_int < 0) begin
          pos_int = pos_int + N;
        end
        pos = W'(pos_int);
        if (!found && req[pos]) begin
          found   = 1'b1;
          win_idx = pos;
        end
      end
    end
  end

  // Next-state logic: hold the grant until ack, re-arbitrate at arbitration points.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;

    if (ack_edge) begin
      ptr_d = ptr_served;
    end

    if (arb_point) begin
      if (|req) begin
        state_d        = GRANT;
        grant_valid_d  = 1'b1;
        grant_idx_d    = win_idx;
        grant_onehot_d = ONEHOT_ONE << win_idx;
      end else begin
        state_d        = IDLE;
        grant_valid_d  = 1'b0;
        grant_idx_d    = '0;
        grant_onehot_d = '0;
      end
    end
  end

  // State and output registers; reset drops any held grant immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= PTR_RESET;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Scoreboard bench for prio_arbiter_rr (N=4): directed sequences plus random traffic.
module tb_prio_arbiter_rr;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;

  prio_arbiter_rr #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mode         (mode),
    .ack          (ack),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;
  int   cycle_no   = 0;
  bit   done       = 0;

  // Reference model state: is a grant held, which index, round-robin pointer.
  bit m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = N - 1;

  // Arbitration rule: mode 0 -> highest set index; mode 1 -> first set bit
  // walking down from ptr with wrap-around.
  function automatic int pick(input logic [N-1:0] r, input bit m, input int p);
    if (!m) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p - k + N) % N;
        if (r[j]) return j;
      end
    end
    return 0;
  endfunction

  // Drive one cycle of inputs and push what the outputs must be after the next edge.
  task automatic step(input logic [N-1:0] r, input bit m, input bit a, input bit rn);
    exp_t e;
    @(negedge clk);
    req   = r;
    mode  = m;
    ack   = a;
    rst_n = rn;
    if (!rn) begin
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = N - 1;
    end else if (!m_valid) begin
      if (r != '0) begin
        m_valid = 1;
        m_idx   = pick(r, m, m_ptr);
      end
    end else if (a) begin
      m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
      if (r != '0) begin
        m_idx = pick(r, m, m_ptr);
      end else begin
        m_valid = 0;
        m_idx   = 0;
      end
    end
    e.valid = m_valid;
    e.idx   = m_idx;
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge, pop one expectation and compare the registered outputs.
  initial begin
    exp_t         e;
    logic [N-1:0] exp_oh;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() != 0) begin
        e      = exp_q.pop_front();
        exp_oh = e.valid ? (N'(1) << e.idx) : '0;
        n_compared++;
        if (grant_valid !== e.valid) begin
          n_mismatch++;
          $display("FAIL grant_valid cyc=%0d got=%0b want=%0b", cycle_no, grant_valid, e.valid);
        end
        n_compared++;
        if (grant_idx !== W'(e.idx)) begin
          n_mismatch++;
          $display("FAIL grant_idx cyc=%0d got=%0d want=%0d", cycle_no, grant_idx, e.idx);
        end
        n_compared++;
        if (grant_onehot !== exp_oh) begin
          n_mismatch++;
          $display("FAIL grant_onehot cyc=%0d got=%b want=%b", cycle_no, grant_onehot, exp_oh);
        end
        $display("cyc=%0d req=%b mode=%0b ack=%0b rst_n=%0b -> valid=%0b idx=%0d onehot=%b",
                 cycle_no, req, mode, ack, rst_n, grant_valid, grant_idx, grant_onehot);
      end
    end
  end

  initial begin
    req   = '0;
    mode  = 1'b0;
    ack   = 1'b0;
    rst_n = 1'b0;

    // Reset with requests present, then the first grant goes to index 3.
    step(4'b1111, 0, 0, 0);
    step(4'b1111, 0, 0, 0);
    step(4'b1111, 0, 0, 1);

    // Fixed hold: grant frozen while req changes, then ack moves it.
    step(4'b0000, 0, 0, 0);
    step(4'b1011, 0, 0, 1);
    repeat (3) step(4'b0010, 0, 0, 1);
    step(4'b0010, 0, 1, 1);
    step(4'b0000, 0, 1, 1);

    // Fixed starvation: index 2 wins every cycle.
    repeat (6) step(4'b0101, 0, 1, 1);
    step(4'b0000, 0, 1, 1);

    // Round-robin rotation over all four, then over 1010.
    step(4'b0000, 1, 0, 0);
    repeat (6) step(4'b1111, 1, 1, 1);
    step(4'b0000, 1, 0, 0);
    repeat (4) step(4'b1010, 1, 1, 1);

    // Drain to idle, then spurious acks while idle.
    step(4'b0000, 1, 0, 0);
    step(4'b0000, 1, 1, 1);
    step(4'b0100, 1, 0, 1);
    step(4'b0000, 1, 1, 1);
    step(4'b0000, 1, 1, 1);
    step(4'b0000, 1, 1, 1);
    repeat (4) step(4'b1111, 1, 1, 1);

    // Reset in the middle of a held grant on index 2.
    step(4'b0000, 1, 1, 1);
    step(4'b0100, 1, 0, 1);
    step(4'b1111, 1, 0, 1);
    step(4'b1111, 1, 0, 0);
    step(4'b1111, 1, 0, 1);
    step(4'b1111, 1, 1, 1);

    // Random traffic: sparse requests, occasional mode flips and resets.
    for (int t = 0; t < 600; t++) begin
      logic [N-1:0] r;
      bit           m, a, rn;
      r  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      m  = ($urandom_range(0, 9) == 0) ? ~mode : mode;
      a  = ($urandom_range(0, 2) != 0);
      rn = ($urandom_range(0, 63) != 0);
      step(r, m, a, rn);
    end

    // Let the last expectation be consumed; anything left over means a stalled monitor.
    repeat (3) @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatch++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
